spi_cmd_decoder: RTL and testbench
==================================

# spi_cmd_decoder

Command-layer stage directly downstream of the SPI controller's receive FIFO and upstream of its transmit FIFO. It pops host bytes from the SPI-to-internal FIFO, parses read/write register commands, and maintains a bank of control registers driving the DFCTRL datapath. Read responses are pushed into the internal-to-SPI FIFO for the host to clock out.

## Interface
- RW_REGS, 12, number of read/write control registers (addresses 0..RW_REGS-1)
- ADDR_BITS, 4, register address width; addresses RW_REGS..2^ADDR_BITS-1 are read-only status

- internal_clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- rx_data  in  8  receive FIFO read data; valid whenever rx_empty=0 (show-ahead)
- rx_empty  in  1  receive FIFO empty
- rx_rd_req  out  1  pop receive FIFO; byte on rx_data consumed at this edge
- tx_data  out  8  transmit FIFO write data
- tx_full  in  1  transmit FIFO full
- tx_wr_req  out  1  push tx_data at this edge
- status_in  in  (2^ADDR_BITS-RW_REGS)*8  read-only status bytes; byte k maps to address RW_REGS+k
- ctrl_regs  out  RW_REGS*8  control registers; register i at bits [8i+7:8i]
- busy  out  1  high in any state other than IDLE
- cmd_done  out  1  one-cycle pulse on command completion
- err_count  out  8  count of rejected command bytes, saturating at 255

## Operation
- Command byte: bit7 = 1 write / 0 read; bits[6:ADDR_BITS] reserved, must be 0; bits[ADDR_BITS-1:0] = start address.
- Length byte follows: N = 0..255 data bytes.
- Write: N bytes follow from host, stored at addr, addr+1, …; address wraps modulo 2^ADDR_BITS.
- Read: N bytes pushed to transmit FIFO from addr, addr+1, …, same wrap.
- Write to a status address: byte popped and discarded; no error.
- Read of an address ≥ RW_REGS returns the matching status_in byte, sampled in the push cycle.
- Reserved bits nonzero: byte popped, err_count increments (saturating), state stays IDLE; the next byte is treated as a new command byte.
- FSM states:
  - IDLE: pop when !rx_empty; latch dir/addr -> LEN, or reject as above.
  - LEN: pop when !rx_empty; N=0 -> DONE; else load counter = N -> WDATA (write) or RDATA (read).
  - WDATA: pop when !rx_empty; write byte, addr+1, counter-1; counter reaching 0 -> DONE.
  - RDATA: push when !tx_full; addr+1, counter-1; counter reaching 0 -> DONE.
  - DONE: cmd_done=1 for one cycle -> IDLE.
- rx_rd_req = (state ∈ {IDLE, LEN, WDATA}) && !rx_empty. Combinational from registered state; never asserted while empty.
- tx_wr_req = (state == RDATA) && !tx_full. tx_data is the combinational register/status read at the current address.

## Timing
- Reset values: ctrl_regs all 0, err_count 0, state IDLE, busy 0, cmd_done 0, rx_rd_req 0, tx_wr_req 0. Counter and address are don't-care.
- Throughput: one byte per cycle in every pop/push state while data or space is available. Stalls (rx_empty, tx_full) hold state, counter and address unchanged.
- A written register value is visible on ctrl_regs the cycle after its pop edge.
- Latency from the edge popping the final write byte, or pushing the final read byte, to cmd_done high: 1 cycle.
- Minimum command cost: write of N bytes = N+3 cycles; read of N bytes = N+3 cycles, all without stalls.
- Reset mid-command: returns to IDLE next edge and clears registers. FIFOs are not flushed; remaining host bytes are parsed as new commands.
- Back-to-back commands: a command byte can be popped in the first IDLE cycle after DONE.

## Test plan
- Reset, then write cmd 0x83, len 0x02, data 0xAA, 0x55 -> reg3=0xAA, reg4=0x55; cmd_done pulses once, 1 cycle after the last pop; other regs stay 0.
- Write cmd 0x8F, len 3, data 1,2,3 with RW_REGS=12 -> reg15 write ignored; reg0=2, reg1=3 (wrap); err_count=0.
- Read cmd 0x0A, len 4, with reg10=0x11, reg11=0x22, status_in bytes 0xC0, 0xC1 -> tx sequence 0x11, 0x22, 0xC0, 0xC1; hold tx_full high for 5 cycles mid-burst -> no push and no address advance during the stall.
- Bytes 0x40 then a valid read of len 0 -> err_count=1, second command completes with cmd_done and no tx pushes; 300 bad bytes -> err_count=255.
- Insert rx_empty gaps between every byte of a 4-byte write -> rx_rd_req never asserted while empty; final register contents are correct.
- Assert reset during WDATA after 1 of 3 bytes -> next cycle busy=0 and all regs=0; the remaining 2 bytes are parsed as commands (0x00-style bytes start reads).

Source files
------------

// File: rtl/spi_cmd_decoder.sv
// Command layer between the SPI receive/transmit FIFOs: parses register read/write
// commands from host bytes and holds the control register bank.
module spi_cmd_decoder #(
    parameter int RW_REGS   = 12,
    parameter int ADDR_BITS = 4
) (
    input  logic                                  internal_clk,
    input  logic                                  reset,
    input  logic [7:0]                            rx_data,
    input  logic                                  rx_empty,
    output logic                                  rx_rd_req,
    output logic [7:0]                            tx_data,
    input  logic                                  tx_full,
    output logic                                  tx_wr_req,
    input  logic [(2**ADDR_BITS-RW_REGS)*8-1:0]   status_in,
    output logic [RW_REGS*8-1:0]                  ctrl_regs,
    output logic                                  busy,
    output logic                                  cmd_done,
    output logic [7:0]                            err_count
);

    localparam logic [ADDR_BITS:0] RW_LIMIT = (ADDR_BITS+1)'(RW_REGS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_WDATA = 3'd2,
        ST_RDATA = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                  state_r, state_s;
    logic [ADDR_BITS-1:0]    addr_r, addr_s;
    logic [7:0]              cnt_r, cnt_s;
    logic                    dir_wr_r, dir_wr_s;
    logic [7:0]              err_r, err_s;
    logic [RW_REGS*8-1:0]    ctrl_r;
    logic                    wr_en_s;
    logic [(2**ADDR_BITS)*8-1:0] rd_bytes_s;

    // Any nonzero bit between bit 6 and the address field rejects the command byte
    function automatic logic reserved_bad(input logic [7:0] b);
        logic [6:0] upper;
        upper = b[6:0] >> ADDR_BITS;
        return (upper != 7'd0);
    endfunction

    function automatic logic addr_is_rw(input logic [ADDR_BITS-1:0] a);
        return ({1'b0, a} < RW_LIMIT);
    endfunction

    // Register and status bytes form one flat map indexed by the current address
    always_comb begin
        rd_bytes_s = {status_in, ctrl_r};
        tx_data    = rd_bytes_s[{addr_r, 3'b000} +: 8];
    end

    // Next-state, handshake and datapath update decode
    always_comb begin
        state_s   = state_r;
        addr_s    = addr_r;
        cnt_s     = cnt_r;
        dir_wr_s  = dir_wr_r;
        err_s     = err_r;
        wr_en_s   = 1'b0;
        rx_rd_req = 1'b0;
        tx_wr_req = 1'b0;
        busy      = (state_r != ST_IDLE);
        cmd_done  = (state_r == ST_DONE);
        case (state_r)
            ST_IDLE: begin
                if (!rx_empty) begin
                    rx_rd_req = 1'b1;
                    if (reserved_bad(rx_data)) begin
                        err_s = (err_r == 8'hFF) ? err_r : (err_r + 8'd1);
                    end else begin
                        dir_wr_s = rx_data[7];
                        addr_s   = rx_data[ADDR_BITS-1:0];
                        state_s  = ST_LEN;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LEN: begin
                if (!rx_empty) begin
                    rx_rd_req = 1'b1;
                    cnt_s     = rx_data;
                    if (rx_data == 8'd0) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = dir_wr_r ? ST_WDATA : ST_RDATA;
                    end
                end else begin
                    state_s = ST_LEN;
                end
            end
            ST_WDATA: begin
                if (!rx_empty) begin
                    rx_rd_req = 1'b1;
                    wr_en_s   = addr_is_rw(addr_r);
                    addr_s    = addr_r + ADDR_BITS'(1);
                    cnt_s     = cnt_r - 8'd1;
                    state_s   = (cnt_r == 8'd1) ? ST_DONE : ST_WDATA;
                end else begin
                    state_s = ST_WDATA;
                end
            end
            ST_RDATA: begin
                if (!tx_full) begin
                    tx_wr_req = 1'b1;
                    addr_s    = addr_r + ADDR_BITS'(1);
                    cnt_s     = cnt_r - 8'd1;
                    state_s   = (cnt_r == 8'd1) ? ST_DONE : ST_RDATA;
                end else begin
                    state_s = ST_RDATA;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, pointer, error counter and control register bank
    always_ff @(posedge internal_clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            addr_r   <= '0;
            cnt_r    <= 8'd0;
            dir_wr_r <= 1'b0;
            err_r    <= 8'd0;
            ctrl_r   <= '0;
        end else begin
            state_r  <= state_s;
            addr_r   <= addr_s;
            cnt_r    <= cnt_s;
            dir_wr_r <= dir_wr_s;
            err_r    <= err_s;
            if (wr_en_s) begin
                ctrl_r[{addr_r, 3'b000} +: 8] <= rx_data;
            end
        end
    end

    assign ctrl_regs = ctrl_r;
    assign err_count = err_r;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed bench for spi_cmd_decoder: byte-level host commands with hand-computed
// register, response and error-count expectations.
module tb_spi_cmd_decoder;

    logic        internal_clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_empty;
    logic        rx_rd_req;
    logic [7:0]  tx_data;
    logic        tx_full;
    logic        tx_wr_req;
    logic [31:0] status_in;
    logic [95:0] ctrl_regs;
    logic        busy;
    logic        cmd_done;
    logic [7:0]  err_count;

    int checks;
    int failures;
    int done_cnt;
    int bad_pop;
    logic [7:0] tx_log[$];

    spi_cmd_decoder dut (
        .internal_clk(internal_clk),
        .reset(reset),
        .rx_data(rx_data),
        .rx_empty(rx_empty),
        .rx_rd_req(rx_rd_req),
        .tx_data(tx_data),
        .tx_full(tx_full),
        .tx_wr_req(tx_wr_req),
        .status_in(status_in),
        .ctrl_regs(ctrl_regs),
        .busy(busy),
        .cmd_done(cmd_done),
        .err_count(err_count)
    );

    initial internal_clk = 1'b0;
    always #5 internal_clk = ~internal_clk;

    // Record what the FIFOs would see at each active edge
    always @(posedge internal_clk) begin
        if (tx_wr_req === 1'b1) tx_log.push_back(tx_data);
        if (cmd_done === 1'b1) done_cnt++;
        if (rx_rd_req === 1'b1 && rx_empty === 1'b1) bad_pop++;
    end

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge internal_clk);
        #1;
    endtask

    // Offer one byte and wait (bounded) for the decoder to pop it
    task automatic push_byte(input logic [7:0] b);
        logic popped;
        popped   = 1'b0;
        rx_data  = b;
        rx_empty = 1'b0;
        for (int i = 0; i < 16 && !popped; i++) begin
            #1;
            if (rx_rd_req === 1'b1) popped = 1'b1;
            tick();
        end
        rx_empty = 1'b1;
        check("pop_taken", {95'd0, popped}, 96'd1);
    endtask

    task automatic gap(input int n);
        rx_empty = 1'b1;
        for (int i = 0; i < n; i++) begin
            #1;
            check("no_pop_when_empty", {95'd0, rx_rd_req}, 96'd0);
            tick();
        end
    endtask

    initial begin
        logic [95:0] exp_regs;
        int          base;
        int          dc;
        checks    = 0;
        failures  = 0;
        done_cnt  = 0;
        bad_pop   = 0;
        reset     = 1'b1;
        rx_data   = 8'h00;
        rx_empty  = 1'b1;
        tx_full   = 1'b0;
        status_in = 32'h0000_C1C0;
        exp_regs  = 96'd0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_busy", {95'd0, busy}, 96'd0);
        check("rst_done", {95'd0, cmd_done}, 96'd0);
        check("rst_err", {88'd0, err_count}, 96'd0);
        check("rst_regs", ctrl_regs, 96'd0);
        check("rst_rdreq", {95'd0, rx_rd_req}, 96'd0);
        check("rst_wrreq", {95'd0, tx_wr_req}, 96'd0);

        // Write 0xAA,0x55 to regs 3,4
        dc = done_cnt;
        push_byte(8'h83);
        push_byte(8'h02);
        push_byte(8'hAA);
        push_byte(8'h55);
        exp_regs[24 +: 8] = 8'hAA;
        exp_regs[32 +: 8] = 8'h55;
        check("wr1_done_latency", {95'd0, cmd_done}, 96'd1);
        check("wr1_regs", ctrl_regs, exp_regs);
        tick();
        tick();
        check("wr1_done_cleared", {95'd0, cmd_done}, 96'd0);
        check("wr1_idle", {95'd0, busy}, 96'd0);
        check("wr1_done_once", 96'(done_cnt - dc), 96'd1);

        // Write starting at status addr 15, wrapping to regs 0,1
        push_byte(8'h8F);
        push_byte(8'h03);
        push_byte(8'h01);
        push_byte(8'h02);
        push_byte(8'h03);
        exp_regs[0 +: 8] = 8'h02;
        exp_regs[8 +: 8] = 8'h03;
        check("wr2_wrap_regs", ctrl_regs, exp_regs);
        check("wr2_err", {88'd0, err_count}, 96'd0);
        tick();

        // Preload regs 10,11 then read 4 bytes across into status, with a tx stall
        push_byte(8'h8A);
        push_byte(8'h02);
        push_byte(8'h11);
        push_byte(8'h22);
        exp_regs[80 +: 8] = 8'h11;
        exp_regs[88 +: 8] = 8'h22;
        tick();
        check("wr3_regs", ctrl_regs, exp_regs);
        base = tx_log.size();
        push_byte(8'h0A);
        push_byte(8'h04);
        check("rd_first_req", {95'd0, tx_wr_req}, 96'd1);
        check("rd_first_data", {88'd0, tx_data}, 96'h11);
        tick();
        tick();
        tx_full = 1'b1;
        #1;
        check("rd_stall_req", {95'd0, tx_wr_req}, 96'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rd_stall_addr_hold", {88'd0, tx_data}, 96'hC0);
            check("rd_stall_no_push", 96'(tx_log.size() - base), 96'd2);
        end
        tx_full = 1'b0;
        tick();
        tick();
        check("rd_done", {95'd0, cmd_done}, 96'd1);
        check("rd_count", 96'(tx_log.size() - base), 96'd4);
        if (tx_log.size() >= base + 4) begin
            check("rd_b0", {88'd0, tx_log[base]}, 96'h11);
            check("rd_b1", {88'd0, tx_log[base+1]}, 96'h22);
            check("rd_b2", {88'd0, tx_log[base+2]}, 96'hC0);
            check("rd_b3", {88'd0, tx_log[base+3]}, 96'hC1);
        end
        tick();

        // Rejected command byte followed by a zero-length read
        push_byte(8'h40);
        check("rej_err1", {88'd0, err_count}, 96'd1);
        check("rej_idle", {95'd0, busy}, 96'd0);
        base = tx_log.size();
        push_byte(8'h00);
        push_byte(8'h00);
        check("rd0_done", {95'd0, cmd_done}, 96'd1);
        tick();
        check("rd0_no_push", 96'(tx_log.size() - base), 96'd0);
        for (int i = 0; i < 300; i++) push_byte(8'h70);
        check("rej_saturate", {88'd0, err_count}, 96'd255);
        check("rej_regs_kept", ctrl_regs, exp_regs);

        // 4-byte write with empty gaps between every byte
        push_byte(8'h84);
        gap(2);
        push_byte(8'h04);
        gap(3);
        push_byte(8'h10);
        gap(1);
        push_byte(8'h20);
        gap(2);
        push_byte(8'h30);
        gap(1);
        push_byte(8'h40);
        exp_regs[32 +: 8] = 8'h10;
        exp_regs[40 +: 8] = 8'h20;
        exp_regs[48 +: 8] = 8'h30;
        exp_regs[56 +: 8] = 8'h40;
        check("gap_done", {95'd0, cmd_done}, 96'd1);
        check("gap_regs", ctrl_regs, exp_regs);
        check("gap_no_empty_pop", 96'(bad_pop), 96'd0);
        tick();

        // Reset in the middle of a 3-byte write; remaining bytes become commands
        push_byte(8'h80);
        push_byte(8'h03);
        push_byte(8'h99);
        check("mid_busy", {95'd0, busy}, 96'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("mid_rst_busy", {95'd0, busy}, 96'd0);
        check("mid_rst_regs", ctrl_regs, 96'd0);
        check("mid_rst_err", {88'd0, err_count}, 96'd0);
        base = tx_log.size();
        push_byte(8'h05);
        check("mid_cmd_len_state", {95'd0, busy}, 96'd1);
        push_byte(8'h00);
        check("mid_cmd_done", {95'd0, cmd_done}, 96'd1);
        tick();
        check("mid_no_push", 96'(tx_log.size() - base), 96'd0);
        check("mid_idle", {95'd0, busy}, 96'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
